box_mean_threshold: RTL and testbench

//  Upstream stage of `threshold`: scans the 8-bit grey image memory, computes the local
//  (2*RADIUS+1)^2 box mean per pixel, subtracts OFFSET, writes the result into the

---
 rtl/box_mean_threshold.sv | 205 ++++++++++++++++++++
 tb/tb_box_mean_threshold.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/box_mean_threshold.sv
`default_nettype none
// ============================================================================
// Module  : box_mean_threshold
// Brief   : One-shot raster scan computing a (2R+1)^2 box mean minus OFFSET
//           per pixel and writing it to the threshold memory.
// Rev     : 1.0  initial release
// ============================================================================
module box_mean_threshold #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int RADIUS      = 2,
    parameter int OFFSET      = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oThresholdCol,
    output logic [HEIGHT_BITS-1:0] oThresholdRow,
    output logic [7:0]             oThresholdData,
    output logic                   oThresholdWren,
    output logic                   finished
);

    localparam int TAPS  = (2*RADIUS+1) * (2*RADIUS+1);
    localparam int RECIP = (65536 + TAPS/2) / TAPS;
    localparam int SUM_W = 8 + $clog2(TAPS);
    localparam int TAP_W = (RADIUS == 0) ? 1 : $clog2(2*RADIUS+1);
    localparam int XW    = WIDTH_BITS + TAP_W + 1;
    localparam int YW    = HEIGHT_BITS + TAP_W + 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(2*RADIUS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_CALC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH_BITS-1:0]    col_q, col_d;
    logic [HEIGHT_BITS-1:0]   row_q, row_d;
    logic [TAP_W-1:0]         dx_q, dx_d;
    logic [TAP_W-1:0]         dy_q, dy_d;
    logic                     acc_en_q, acc_en_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic [WIDTH_BITS-1:0]    wcol_q, wcol_d;
    logic [HEIGHT_BITS-1:0]   wrow_q, wrow_d;
    logic [7:0]               wdata_q, wdata_d;
    logic                     wren_q, wren_d;
    logic                     finished_q, finished_d;

    // Tap coordinates: pixel + (d - RADIUS), replicated at the image border
    logic [XW-1:0]            w_sx, w_ox;
    logic [YW-1:0]            w_sy, w_oy;
    logic [WIDTH_BITS-1:0]    w_tap_col;
    logic [HEIGHT_BITS-1:0]   w_tap_row;

    always_comb begin
        w_sx = XW'(col_q) + XW'(dx_q);
        w_ox = w_sx - XW'(RADIUS);
        if (w_sx < XW'(RADIUS))
            w_tap_col = '0;
        else if (w_ox > XW'((1 << WIDTH_BITS) - 1))
            w_tap_col = '1;
        else
            w_tap_col = w_ox[WIDTH_BITS-1:0];

        w_sy = YW'(row_q) + YW'(dy_q);
        w_oy = w_sy - YW'(RADIUS);
        if (w_sy < YW'(RADIUS))
            w_tap_row = '0;
        else if (w_oy > YW'((1 << HEIGHT_BITS) - 1))
            w_tap_row = '1;
        else
            w_tap_row = w_oy[HEIGHT_BITS-1:0];
    end

    assign oImageCol = (state_q == S_READ) ? w_tap_col : '0;
    assign oImageRow = (state_q == S_READ) ? w_tap_row : '0;

    // Rounded mean via fixed-point reciprocal, saturated to 8 bits, then floored offset
    logic [31:0] w_prod;
    logic [31:0] w_mean_full;
    logic [7:0]  w_mean;
    logic [7:0]  w_thr;

    always_comb begin
        w_prod      = 32'(sum_q) * 32'(RECIP) + 32'd32768;
        w_mean_full = w_prod >> 16;
        w_mean      = (w_mean_full > 32'd255) ? 8'hFF : w_mean_full[7:0];
        w_thr       = (w_mean > 8'(OFFSET)) ? (w_mean - 8'(OFFSET)) : 8'd0;
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        acc_en_d   = 1'b0;
        sum_d      = sum_q;
        wcol_d     = wcol_q;
        wrow_d     = wrow_q;
        wdata_d    = wdata_q;
        wren_d     = 1'b0;
        finished_d = finished_q;

        // Memory data lags its address by one cycle, so accumulation follows acc_en_q
        if (acc_en_q)
            sum_d = sum_q + SUM_W'(iImageData);

        case (state_q)
            S_IDLE: begin
                state_d = S_READ;
                sum_d   = '0;
                dx_d    = '0;
                dy_d    = '0;
            end
            S_READ: begin
                acc_en_d = 1'b1;
                if (dx_q == TAP_LAST) begin
                    dx_d = '0;
                    if (dy_q == TAP_LAST) begin
                        dy_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        dy_d = dy_q + 1'b1;
                    end
                end else begin
                    dx_d = dx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                state_d = S_WRITE;
                wren_d  = 1'b1;
                wcol_d  = col_q;
                wrow_d  = row_q;
                wdata_d = w_thr;
            end
            S_WRITE: begin
                if ((col_q == '1) && (row_q == '1)) begin
                    state_d    = S_DONE;
                    finished_d = 1'b1;
                end else begin
                    col_d   = col_q + 1'b1;
                    if (col_q == '1)
                        row_d = row_q + 1'b1;
                    sum_d   = '0;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            acc_en_q   <= 1'b0;
            sum_q      <= '0;
            wcol_q     <= '0;
            wrow_q     <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            acc_en_q   <= acc_en_d;
            sum_q      <= sum_d;
            wcol_q     <= wcol_d;
            wrow_q     <= wrow_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            finished_q <= finished_d;
        end
    end

    assign oThresholdCol  = wcol_q;
    assign oThresholdRow  = wrow_q;
    assign oThresholdData = wdata_q;
    assign oThresholdWren = wren_q;
    assign finished       = finished_q;

endmodule
`default_nettype wire

// File: tb/tb_box_mean_threshold.sv
`default_nettype none
// ============================================================================
// Module  : tb_box_mean_threshold
// Brief   : Scoreboard bench for box_mean_threshold on a reduced 8x8 image.
// Rev     : 1.0  initial release
// ============================================================================
module tb_box_mean_threshold;

    localparam int WB    = 3;
    localparam int HB    = 3;
    localparam int R     = 2;
    localparam int OFF   = 7;
    localparam int W     = 1 << WB;
    localparam int H     = 1 << HB;
    localparam int NPIX  = W * H;
    localparam int N     = (2*R+1) * (2*R+1);
    localparam int LAT   = N + 3;
    localparam int RECIP = (65536 + N/2) / N;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [WB-1:0] oImageCol, oThresholdCol;
    logic [HB-1:0] oImageRow, oThresholdRow;
    logic [7:0]    iImageData, oThresholdData;
    logic          oThresholdWren, finished;

    box_mean_threshold #(
        .WIDTH_BITS (WB),
        .HEIGHT_BITS(HB),
        .RADIUS     (R),
        .OFFSET     (OFF)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .oImageCol     (oImageCol),
        .oImageRow     (oImageRow),
        .iImageData    (iImageData),
        .oThresholdCol (oThresholdCol),
        .oThresholdRow (oThresholdRow),
        .oThresholdData(oThresholdData),
        .oThresholdWren(oThresholdWren),
        .finished      (finished)
    );

    always #5 clock = ~clock;

    // Synchronous image memory: data valid one cycle after the address
    logic [7:0] img [NPIX];
    always @(posedge clock) iImageData <= img[{oImageRow, oImageCol}];

    typedef struct {
        int col;
        int row;
        int data;
        int cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         writes = 0;
    int         last_wr_cyc = 0;
    int         cyc;
    logic [7:0] got [NPIX];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: box sum over clamped coordinates, rounded reciprocal mean, floored offset
    function automatic int ref_thr(input int c, input int r);
        int s;
        int m;
        s = 0;
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                int x;
                int y;
                x = c + dx;
                y = r + dy;
                if (x < 0) x = 0;
                if (x > W-1) x = W-1;
                if (y < 0) y = 0;
                if (y > H-1) y = H-1;
                s += int'(img[y*W + x]);
            end
        end
        m = (s * RECIP + 32768) >>> 16;
        if (m > 255) m = 255;
        return (m > OFF) ? m - OFF : 0;
    endfunction

    // Rising edges since reset release; the first write is expected after LAT of them
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (reset && oThresholdWren) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wren col=%0d row=%0d data=%0d",
                         oThresholdCol, oThresholdRow, oThresholdData);
            end else begin
                e = sb.pop_front();
                chk("wr_col", int'(oThresholdCol), e.col);
                chk("wr_row", int'(oThresholdRow), e.row);
                chk("wr_data", int'(oThresholdData), e.data);
                chk("wr_cycle", cyc, e.cyc);
                chk("finished_during_scan", int'(finished), 0);
                got[e.row*W + e.col] = oThresholdData;
                last_wr_cyc = cyc;
                writes++;
            end
        end
    end

    task automatic fill(input int v);
        for (int i = 0; i < NPIX; i++) img[i] = 8'(v);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wren"}, int'(oThresholdWren), 0);
        chk({tag, "_finished"}, int'(finished), 0);
        chk({tag, "_img_col"}, int'(oImageCol), 0);
        chk({tag, "_img_row"}, int'(oImageRow), 0);
        chk({tag, "_thr_col"}, int'(oThresholdCol), 0);
        chk({tag, "_thr_row"}, int'(oThresholdRow), 0);
        chk({tag, "_thr_data"}, int'(oThresholdData), 0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b0;
        #1 check_reset_outputs("rst");
    endtask

    task automatic start_scan();
        sb.delete();
        writes = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                sb.push_back('{c, r, ref_thr(c, r), LAT * (r*W + c + 1)});
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_finish();
        int n;
        n = 0;
        while (!finished && n < NPIX*LAT + 100) begin
            @(negedge clock);
            n++;
        end
        chk("finished_rises", int'(finished), 1);
        chk("writes_total", writes, NPIX);
        chk("scoreboard_empty", sb.size(), 0);
        chk("finished_cycle", cyc, last_wr_cyc + 1);
        repeat (30) @(negedge clock);
        chk("finished_held", int'(finished), 1);
        chk("no_writes_after_done", writes, NPIX);
    endtask

    task automatic count_bad(input string name, input int v);
        int bad;
        bad = 0;
        for (int i = 0; i < NPIX; i++) if (int'(got[i]) != v) bad++;
        chk(name, bad, 0);
    endtask

    initial begin
        int n;
        fill(0);
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("init");

        fill(100);
        start_scan();
        wait_finish();
        count_bad("uniform100_is93", 93);

        do_reset();
        fill(0);
        start_scan();
        wait_finish();
        count_bad("zero_floor", 0);

        do_reset();
        fill(255);
        start_scan();
        wait_finish();
        count_bad("all255_is248", 248);

        do_reset();
        fill(0);
        img[0] = 8'd255;
        start_scan();
        wait_finish();
        chk("single_0_0", int'(got[0]), 85);
        chk("single_2_2", int'(got[2*W + 2]), 3);
        chk("single_3_3", int'(got[3*W + 3]), 0);

        for (int k = 0; k < 2; k++) begin
            do_reset();
            fill_random();
            start_scan();
            wait_finish();
        end

        // Abort while pixel (5,3) is being read, then expect a full rescan from (0,0)
        do_reset();
        fill_random();
        start_scan();
        n = 0;
        while (writes < 3*W + 5 && n < NPIX*LAT) begin
            @(negedge clock);
            n++;
        end
        chk("reach_abort_pixel", writes, 3*W + 5);
        repeat (6) @(posedge clock);
        #2 reset = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) @(negedge clock);
        start_scan();
        wait_finish();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
